// File: rtl/bus_generator_arbiter_pkg.sv
// Shared definitions for the bus generator/arbiter.
// Contents:
//   ID_W, BROADCAST  destination-ID width and the default broadcast ID
//   PKT_MAX_W        widest packet id_of() accepts (callers zero-extend)
//   state_t          per-bus arbiter state
//   id_of()          extracts the destination ID from the packet MSBs
package bus_gen_pkg;

  localparam int unsigned ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
  localparam int unsigned PKT_MAX_W = 1024;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  // pkt_w is the real packet width; the ID sits in its top ID_W bits.
  function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX_W-1:0] pkt,
                                            input int unsigned pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_if.sv
// Driver-side bus bundle for bus_generator_arbiter.
// Signals (per bus b, per driver d):
//   pndng[b][d]   driver FIFO non-empty
//   D_pop[b][d]   FIFO head data
//   pop[b][d]     one-cycle pop strobe to the source FIFO
//   push[b][d]    one-cycle push strobe to the destination
//   D_push[b][d]  packet on the bus, identical for every driver of a bus
// Modports: master = FIFO/driver side, slave = arbiter side.
interface bus_generator_arbiter_if #(
  parameter int unsigned bits    = 1,
  parameter int unsigned drvrs   = 8,
  parameter int unsigned pckg_sz = 16
);

  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

  modport master (output pndng, D_pop, input pop, push, D_push);
  modport slave (input pndng, D_pop, output pop, push, D_push);

endinterface

// File: rtl/bus_generator_arbiter_lane.sv
// One bus of the arbiter: round-robin grant, pop, packet register, push decode.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   pndng        per-driver FIFO non-empty
//   d_pop        per-driver FIFO head data
//   pop          one-cycle pop strobe to the granted driver
//   push         one-cycle push strobe(s) to the destination driver(s)
//   d_push       last delivered packet (held until the next delivery)
module bus_arb_lane
  import bus_gen_pkg::*;
#(
  parameter int unsigned     drvrs     = 8,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              d_push
);

  localparam int unsigned IdxW = $clog2(drvrs);
  typedef logic [IdxW-1:0] idx_t;

  state_t             state;
  idx_t               ptr;
  idx_t               grant;
  idx_t               rr_grant;
  idx_t               rr_idx;
  logic               found;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    head_id;
  logic [drvrs-1:0]   push_dec;

  // First pending driver at or after ptr, wrapping drvrs-1 -> 0.
  always_comb begin
    rr_grant = ptr;
    rr_idx   = ptr;
    found    = 1'b0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      rr_idx = idx_t'((32'(ptr) + i) % drvrs);
      if (!found && pndng[rr_idx]) begin
        rr_grant = rr_idx;
        found    = 1'b1;
      end
    end
  end

  // Destination decode of the granted head, registered into push at the POP edge.
  assign head    = d_pop[grant];
  assign head_id = id_of(PKT_MAX_W'(head), pckg_sz);

  always_comb begin
    push_dec = '0;
    for (int unsigned j = 0; j < drvrs; j++) begin
      if (32'(head_id) < drvrs) begin
        push_dec[j] = (j == 32'(head_id));
      end else if (head_id == broadcast) begin
        push_dec[j] = (j != 32'(grant));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      pkt   <= '0;
      pop   <= '0;
      push  <= '0;
    end else begin
      pop  <= '0;
      push <= '0;
      unique case (state)
        IDLE: begin
          if (|pndng) begin
            grant         <= rr_grant;
            pop[rr_grant] <= 1'b1;
            state         <= POP;
          end
        end
        POP: begin
          // Data is taken as sampled here even if pndng has since dropped.
          pkt   <= head;
          push  <= push_dec;
          ptr   <= (grant == idx_t'(drvrs - 1)) ? '0 : grant + 1'b1;
          state <= PUSH;
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign d_push = pkt;

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus model with integrated arbiter for `bits` independent buses of
// `drvrs` drivers each. Each bus grants one pending driver round-robin, pops
// its packet and delivers it to the destination (or all others on broadcast).
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   bus         driver bundle (slave modport): pndng/D_pop in, pop/push/D_push out
module bus_generator_arbiter
  import bus_gen_pkg::*;
#(
  parameter int unsigned     bits      = 1,
  parameter int unsigned     drvrs     = 8,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input logic                     clk,
  input logic                     reset,
  bus_generator_arbiter_if.slave  bus
);

  logic [bits-1:0][pckg_sz-1:0] lane_data;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_arb_lane #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pndng  (bus.pndng[b]),
      .d_pop  (bus.D_pop[b]),
      .pop    (bus.pop[b]),
      .push   (bus.push[b]),
      .d_push (lane_data[b])
    );

    // Every driver on a bus sees the same packet.
    for (genvar j = 0; j < drvrs; j++) begin : g_drv
      assign bus.D_push[b][j] = lane_data[b];
    end
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Bench for bus_generator_arbiter (bits=1, drvrs=8, pckg_sz=16): directed
// scenarios plus a randomized run against a FIFO/round-robin reference model.
module tb_bus_generator_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bus_generator_arbiter_if #(.bits(1), .drvrs(8), .pckg_sz(16)) bus_if ();

  bus_generator_arbiter #(
    .bits      (1),
    .drvrs     (8),
    .pckg_sz   (16),
    .broadcast (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference-model FIFOs for the randomized run.
  logic [15:0] mem [8][16];
  int          hd  [8];
  int          cnt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int src, input logic [15:0] pk);
    bus_if.pndng[0][src] = 1'b1;
    bus_if.D_pop[0][src] = pk;
  endtask

  task automatic clear_inputs();
    bus_if.pndng = '0;
    bus_if.D_pop = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #3;
    total++;
    if (bus_if.pop !== 8'h00) begin
      bad++; $display("FAIL reset_pop got=%h exp=00", bus_if.pop);
    end
    total++;
    if (bus_if.push !== 8'h00) begin
      bad++; $display("FAIL reset_push got=%h exp=00", bus_if.push);
    end
    total++;
    if (bus_if.D_push !== '0) begin
      bad++; $display("FAIL reset_dpush got=%h exp=0", bus_if.D_push);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus_if.pop !== 8'h00 || bus_if.push !== 8'h00) begin
        bad++; $display("FAIL idle_quiet pop=%h push=%h exp=00/00", bus_if.pop, bus_if.push);
      end
    end
  endtask

  task automatic test_single_send();
    offer(2, 16'h05AB);
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h04 || bus_if.push[0] !== 8'h00) begin
      bad++; $display("FAIL single_pop pop=%h push=%h exp=04/00", bus_if.pop[0], bus_if.push[0]);
    end
    bus_if.pndng[0][2] = 1'b0;
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h00 || bus_if.push[0] !== 8'h20) begin
      bad++; $display("FAIL single_push pop=%h push=%h exp=00/20", bus_if.pop[0], bus_if.push[0]);
    end
    total++;
    if (bus_if.D_push[0] !== {8{16'h05AB}}) begin
      bad++; $display("FAIL single_data got=%h exp=8x05AB", bus_if.D_push[0]);
    end
    bus_if.D_pop[0][2] = 16'h0000;
    tick();
    total++;
    if (bus_if.push[0] !== 8'h00 || bus_if.D_push[0] !== {8{16'h05AB}}) begin
      bad++; $display("FAIL single_hold push=%h data=%h exp=00/8x05AB",
                      bus_if.push[0], bus_if.D_push[0]);
    end
  endtask

  task automatic test_broadcast();
    offer(3, 16'hFF12);
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h08) begin
      bad++; $display("FAIL bcast_pop got=%h exp=08", bus_if.pop[0]);
    end
    bus_if.pndng[0][3] = 1'b0;
    tick();
    total++;
    if (bus_if.push[0] !== 8'b1111_0111 || bus_if.D_push[0] !== {8{16'hFF12}}) begin
      bad++; $display("FAIL bcast_push push=%b data=%h exp=11110111/8xFF12",
                      bus_if.push[0], bus_if.D_push[0]);
    end
    tick();
    total++;
    if (bus_if.push[0] !== 8'h00) begin
      bad++; $display("FAIL bcast_oneshot got=%h exp=00", bus_if.push[0]);
    end
  endtask

  task automatic test_invalid_id();
    offer(0, 16'h0A00);
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h01) begin
      bad++; $display("FAIL invalid_pop got=%h exp=01", bus_if.pop[0]);
    end
    bus_if.pndng[0][0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus_if.push[0] !== 8'h00 || bus_if.pop[0] !== 8'h00) begin
        bad++; $display("FAIL invalid_nopush push=%h pop=%h exp=00/00",
                        bus_if.push[0], bus_if.pop[0]);
      end
    end
  endtask

  task automatic test_self_send();
    offer(4, 16'h0477);
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h10) begin
      bad++; $display("FAIL self_pop got=%h exp=10", bus_if.pop[0]);
    end
    bus_if.pndng[0][4] = 1'b0;
    tick();
    total++;
    if (bus_if.push[0] !== 8'h10 || bus_if.D_push[0] !== {8{16'h0477}}) begin
      bad++; $display("FAIL self_push push=%h data=%h exp=10/8x0477",
                      bus_if.push[0], bus_if.D_push[0]);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [7:0] exp;
    reset = 1'b0;
    for (int j = 0; j < 8; j++) offer(j, {8'hEE, 8'(j)});
    tick();
    reset = 1'b1;
    for (int t = 0; t < 27; t++) begin
      tick();
      exp = (t % 3 == 0) ? (8'h01 << ((t / 3) % 8)) : 8'h00;
      total++;
      if (bus_if.pop[0] !== exp || bus_if.push[0] !== 8'h00) begin
        bad++; $display("FAIL fair_order t=%0d pop=%h push=%h exp=%h/00",
                        t, bus_if.pop[0], bus_if.push[0], exp);
      end
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    offer(1, 16'h0612);
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h02) begin
      bad++; $display("FAIL areset_pop got=%h exp=02", bus_if.pop[0]);
    end
    bus_if.pndng[0][1] = 1'b0;
    tick();
    total++;
    if (bus_if.push[0] !== 8'h40) begin
      bad++; $display("FAIL areset_push got=%h exp=40", bus_if.push[0]);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus_if.push[0] !== 8'h00 || bus_if.D_push[0] !== '0 || bus_if.pop[0] !== 8'h00) begin
      bad++; $display("FAIL areset_clear push=%h data=%h pop=%h exp=0",
                      bus_if.push[0], bus_if.D_push[0], bus_if.pop[0]);
    end
    for (int j = 0; j < 8; j++) offer(j, 16'hEE00);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    total++;
    if (bus_if.pop[0] !== 8'h01) begin
      bad++; $display("FAIL areset_ptr got=%h exp=01", bus_if.pop[0]);
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [7:0]  prev_pop, exp_pop, exp_push, push_vec, id;
    logic [15:0] push_dat, hold, pk;
    int          pop_at, pop_g, push_at, free_at, mptr, g, src, left;
    reset = 1'b0;
    clear_inputs();
    for (int j = 0; j < 8; j++) begin
      hd[j]  = 0;
      cnt[j] = 0;
    end
    tick();
    reset    = 1'b1;
    prev_pop = 8'h00;
    pop_at   = -1;
    push_at  = -1;
    pop_g    = 0;
    push_vec = 8'h00;
    push_dat = 16'h0000;
    hold     = 16'h0000;
    free_at  = 1;
    mptr     = 0;
    for (int k = 1; k <= 500; k++) begin
      tick();
      exp_pop  = (k == pop_at) ? (8'h01 << pop_g) : 8'h00;
      exp_push = (k == push_at) ? push_vec : 8'h00;
      if (k == push_at) hold = push_dat;
      total++;
      if (bus_if.pop[0] !== exp_pop) begin
        bad++; $display("FAIL rand_pop k=%0d got=%h exp=%h", k, bus_if.pop[0], exp_pop);
      end
      total++;
      if (bus_if.push[0] !== exp_push) begin
        bad++; $display("FAIL rand_push k=%0d got=%h exp=%h", k, bus_if.push[0], exp_push);
      end
      total++;
      if (bus_if.D_push[0] !== {8{hold}}) begin
        bad++; $display("FAIL rand_data k=%0d got=%h exp=8x%h", k, bus_if.D_push[0], hold);
      end
      // FIFO consumes its head at the edge closing the cycle pop was high.
      for (int j = 0; j < 8; j++) begin
        if (prev_pop[j] && cnt[j] > 0) begin
          hd[j]  = (hd[j] + 1) % 16;
          cnt[j] = cnt[j] - 1;
        end
      end
      prev_pop = bus_if.pop[0];
      if (k < 300 && $urandom_range(0, 3) == 0) begin
        src = int'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          8: id = 8'hFF;
          9: id = 8'($urandom_range(8, 254));
          default: id = 8'($urandom_range(0, 7));
        endcase
        pk = {id, 8'($urandom_range(0, 255))};
        if (cnt[src] < 16) begin
          mem[src][(hd[src] + cnt[src]) % 16] = pk;
          cnt[src] = cnt[src] + 1;
        end
      end
      for (int j = 0; j < 8; j++) begin
        bus_if.pndng[0][j] = (cnt[j] != 0);
        bus_if.D_pop[0][j] = (cnt[j] != 0) ? mem[j][hd[j]] : 16'h0000;
      end
      // Bus free: the next pending driver from the pointer is granted.
      if (k >= free_at) begin
        g = -1;
        for (int i = 0; i < 8; i++) begin
          if (g < 0 && cnt[(mptr + i) % 8] != 0) g = (mptr + i) % 8;
        end
        if (g >= 0) begin
          pop_at   = k + 1;
          pop_g    = g;
          push_at  = k + 2;
          push_dat = mem[g][hd[g]];
          id       = push_dat[15:8];
          if (id < 8) push_vec = 8'h01 << id;
          else if (id == 8'hFF) push_vec = ~(8'h01 << g);
          else push_vec = 8'h00;
          mptr     = (g + 1) % 8;
          free_at  = k + 3;
        end
      end
    end
    left = 0;
    for (int j = 0; j < 8; j++) left += cnt[j];
    total++;
    if (left != 0) begin
      bad++; $display("FAIL rand_drain got=%0d packets left exp=0", left);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_send();
    test_broadcast();
    test_invalid_id();
    test_self_send();
    test_fairness();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
